// File: rtl/memory_sequence_player_pkg.sv
// memory_sequence_player_pkg: shared state encodings and default timing for the memory game
package memory_sequence_player_pkg;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 4;
  localparam int DEF_ON_CYCLES = 50;
  localparam int DEF_OFF_CYCLES = 25;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/memory_sequence_player_if.sv
// memory_sequence_player_if: start/limit control, RAM read port and LED/status outputs of the player
interface memory_sequence_player_if import memory_sequence_player_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic start;
  logic [AW-1:0] limit;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] leds;
  logic busy;
  logic done;
  modport master(output start, limit, ram_q, input ram_addr, leds, busy, done);
  modport slave(input start, limit, ram_q, output ram_addr, leds, busy, done);
endinterface

// File: rtl/memory_sequence_player_hold_timer.sv
// hold_timer: loadable down-counter that stops at zero and flags it
module hold_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_value : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/memory_sequence_player.sv
// memory_sequence_player: plays RAM words 0..limit on the LEDs with lit and blank phases
module memory_sequence_player import memory_sequence_player_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int ON_CYCLES = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
  input logic clk,
  input logic reset,
  memory_sequence_player_if.slave bus
);
  localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
  state_t state_q, state_d;
  logic [AW-1:0] index_q, index_d, lim_q, lim_d;
  logic [DW-1:0] leds_q, leds_d;
  logic busy_q, busy_d, done_q, done_d;
  logic load, zero;
  logic [TW-1:0] load_value;
  hold_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .zero(zero)
  );
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    lim_d = lim_q;
    leds_d = leds_q;
    load = 1'b0;
    load_value = '0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_FETCH;
        index_d = '0;
        lim_d = bus.limit;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        leds_d = bus.ram_q;
        load = 1'b1;
        load_value = TW'(ON_CYCLES - 1);
        state_d = ST_SHOW;
      end
      ST_SHOW: if (zero) begin
        leds_d = '0;
        load = 1'b1;
        load_value = TW'(OFF_CYCLES - 1);
        state_d = ST_GAP;
      end
      ST_GAP: if (zero) begin
        state_d = index_q == lim_q ? ST_DONE : ST_FETCH;
        index_d = index_q == lim_q ? index_q : index_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      lim_q <= '0;
      leds_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      lim_q <= lim_d;
      leds_q <= leds_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.ram_addr = index_q;
  assign bus.leds = leds_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
